// File: rtl/audio_minmax_pkg.sv
// audio_minmax_pkg: shared widths, scheduler states and signed min/max helpers.
package audio_minmax_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  function automatic logic signed [DEF_DATA_W-1:0] smin(input logic signed [DEF_DATA_W-1:0] a, input logic signed [DEF_DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic signed [DEF_DATA_W-1:0] smax(input logic signed [DEF_DATA_W-1:0] a, input logic signed [DEF_DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/minmax_accum.sv
// minmax_accum: running signed min/max; outputs include the current sample so a
// closing interval can be written in the same cycle its last sample arrives.
module minmax_accum
  import audio_minmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [DATA_W-1:0] min_o,
  output logic signed [DATA_W-1:0] max_o
);
  logic signed [DATA_W-1:0] min_q, max_q;
  assign min_o = load_i ? data_i : smin(min_q, data_i);
  assign max_o = load_i ? data_i : smax(max_q, data_i);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '0;
      max_q <= '0;
    end else if (valid_i) begin
      min_q <= min_o;
      max_q <= max_o;
    end
  end
endmodule

// File: rtl/audio_interval_scheduler.sv
// audio_interval_scheduler: streams N samples from the sample RAM and writes one
// signed {min,max} per L-sample interval into the result RAM.
module audio_interval_scheduler
  import audio_minmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_num_samples,
  input  logic [ADDR_W-1:0] cfg_interval_len,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              smp_rd_en,
  output logic [ADDR_W-1:0] smp_addr,
  input  logic [DATA_W-1:0] smp_rd_data,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [ADDR_W-1:0] num_intervals
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d, l_q, l_d, addr_q, addr_d, cnt_q, cnt_d, idx_q, idx_d, res_addr_q;
  logic v_q, first_q, close_q, done_q, done_d, err_q, err_d, close;
  logic signed [DATA_W-1:0] mn, mx, res_min_q, res_max_q;

  minmax_accum #(.DATA_W(DATA_W)) u_acc (
    .clk(clk), .reset(reset), .valid_i(v_q), .load_i(first_q),
    .data_i(smp_rd_data), .min_o(mn), .max_o(mx)
  );

  assign res_wr_en     = v_q & close_q;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign err_cfg       = err_q;
  assign smp_addr      = addr_q;
  assign num_intervals = idx_q;
  assign res_addr      = res_wr_en ? idx_q : res_addr_q;
  assign res_min       = res_wr_en ? mn : res_min_q;
  assign res_max       = res_wr_en ? mx : res_max_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    l_d       = l_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    idx_d     = res_wr_en ? idx_q + 1'b1 : idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    smp_rd_en = 1'b0;
    close     = (cnt_q == l_q - 1'b1) || (addr_q == n_q - 1'b1);
    case (state_q)
      IDLE: if (start && !abort) begin
        if (cfg_num_samples != '0 && cfg_interval_len != '0) begin
          state_d = RUN;
          n_d     = cfg_num_samples;
          l_d     = cfg_interval_len;
          addr_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else err_d = 1'b1;
      end
      RUN: begin
        smp_rd_en = 1'b1;
        addr_d    = addr_q + 1'b1;
        cnt_d     = close ? '0 : cnt_q + 1'b1;
        state_d   = (addr_q == n_q - 1'b1) ? FLUSH : RUN;
      end
      FLUSH: if (v_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      l_q        <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      v_q        <= 1'b0;
      first_q    <= 1'b0;
      close_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      res_addr_q <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      l_q     <= l_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      // an abort squashes the read already in flight so nothing is written after it
      v_q     <= smp_rd_en & ~abort;
      first_q <= cnt_q == '0;
      close_q <= close;
      done_q  <= done_d;
      err_q   <= err_d;
      if (res_wr_en) begin
        res_addr_q <= idx_q;
        res_min_q  <= mn;
        res_max_q  <= mx;
      end
    end
  end
endmodule
